uart_core: RTL and testbench
============================

// Module: uart_core
// PURPOSE
//  Parametrised UART successor: runtime baud divisor, 5-9 data bits, runtime parity (none/even/odd), 1 or 2 stop bits,
//  16x-oversampled RX with 3-sample majority vote, TX/RX FIFOs, per-character parity/framing flags and sticky overrun.
//  Sits between a register/bus front end and the rx/tx pins.
// PARAMETERS
//  DATA_BITS   8   character width, legal 5..9
//  TX_DEPTH    16  TX FIFO entries, power of 2, >=2
//  RX_DEPTH    16  RX FIFO entries, power of 2, >=2
//  DIV_W       16  width of baud_div
// PORTS
//  clk          in   1            single clock
//  rst          in   1            synchronous, active-high reset
//  rx           in   1            serial input, asynchronous to clk
//  tx           out  1            serial output, idle high
//  baud_div     in   DIV_W        clocks per 16x tick; 0 treated as 1
//  parity_mode  in   2            0 none, 1 even, 2 odd, 3 none
//  stop2        in   1            1 = two stop bits on TX
//  wr_en        in   1            push wr_data into TX FIFO
//  wr_data      in   DATA_BITS    TX character
//  tx_full      out  1            TX FIFO full
//  tx_idle      out  1            TX FIFO empty and TX FSM in IDLE
//  rd_en        in   1            pop RX FIFO head
//  rd_data      out  DATA_BITS    RX FIFO head (first-word fall-through)
//  rd_perr      out  1            parity error flag of head entry
//  rd_ferr      out  1            framing error flag of head entry
//  rx_empty     out  1            RX FIFO empty; rd_data/flags valid only when 0
//  rx_overrun   out  1            sticky: character dropped on full RX FIFO
//  clr_overrun  in   1            clears rx_overrun
// BEHAVIOUR
//  Reset: tx=1, tx_full=0, tx_idle=1, rx_empty=1, rx_overrun=0, rd_*=0; FIFOs flushed; both FSMs IDLE; mid-frame reset aborts frame, tx high next cycle.
//  Tick gen: free-running down-counter, one-cycle tick every max(baud_div,1) clocks; one bit = 16 ticks. Shared by TX and RX.
//  Config (parity_mode, stop2) latched by each FSM at frame start; changes mid-frame take effect next frame.
//  TX FSM IDLE->START->DATA->PARITY(if enabled)->STOP->IDLE; LSB first; even parity = XOR of data bits, odd = inverted.
//   IDLE pops FIFO when non-empty; wr_en on cycle N into empty FIFO with FSM idle -> tx low at cycle N+2 (aligned to next tick).
//   STOP holds tx=1 for 16 or 32 ticks; back-to-back characters have no extra idle gap.
//  wr_en while tx_full and no pop same cycle: ignored, FIFO unchanged.
//  RX: 2-flop synchroniser; IDLE waits for synced rx=0 at a tick. START: majority of samples at ticks 7,8,9; if 1 -> false start, IDLE.
//   DATA/PARITY: majority at ticks 7,8,9 of each bit. STOP: first stop bit only; majority 0 -> ferr=1. After the stop-bit sample
//   the FSM returns to IDLE immediately (re-sync from half-bit; 2nd stop bit never checked).
//   Push {ferr,perr,data} at stop sample; perr=0 when parity disabled. Break (all zeros) reports data=0, ferr=1.
//  RX FIFO full at push: character dropped, rx_overrun=1 unless rd_en same cycle (pop+push on full succeeds).
//  clr_overrun with simultaneous new overrun: rx_overrun stays 1 (set wins).
//  FIFOs: FWFT; simultaneous push+pop on empty -> data passes, count stays 0->1->... as in push-then-pop order: empty stays 0? no: push+pop on empty = push only (pop ignored).
//   rd_en while rx_empty: ignored. Pointers wrap modulo depth; full/empty via extra MSB on pointers.
// STRUCTURE
//  uart_pkg: PAR_NONE/PAR_EVEN/PAR_ODD constants, TX/RX state encodings, OVERSAMPLE=16, SAMPLE_TICKS 7/8/9.
//  Sub-module uart_fifo #(WIDTH,DEPTH): sync FWFT FIFO, instantiated for TX (DATA_BITS) and RX (DATA_BITS+2).
//  Tick gen, TX FSM, RX FSM inline in uart_core.
// TESTING
//  baud_div=2, 8N1, write 0x55 -> tx: 1 start(0), 1010_1010 LSB-first, stop(1); each bit 32 clocks; tx_idle=1 after stop.
//  Loopback tx->rx, 8E2, write 0xA5,0x00,0xFF -> pop 0xA5,0x00,0xFF with perr=ferr=0, in order.
//  RX driven 8O1 with wrong parity on 0x3C, then stop=0 on 0x81 -> entries {0x3C,perr=1,ferr=0}, {0x81,perr=0,ferr=1}.
//  RX_DEPTH=4, send 5 chars without reading -> first 4 held, rx_overrun=1; clr_overrun -> 0; 5th never seen.
//  rx low pulse of 6 ticks then high -> false start, no push, rx_empty stays 1; single-tick glitch inside bit rejected by vote.
//  rst asserted mid-DATA of TX with 3 queued -> tx=1 next cycle, tx_idle=1, nothing further transmitted.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared constants, state encodings and helpers for uart_core.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    localparam int         OVERSAMPLE    = 16;
    localparam logic [3:0] LAST_TICK     = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] SAMPLE_TICK_A = 4'd7;
    localparam logic [3:0] SAMPLE_TICK_B = 4'd8;
    localparam logic [3:0] SAMPLE_TICK_C = 4'd9;

    localparam logic [2:0] TX_IDLE   = 3'd0;
    localparam logic [2:0] TX_START  = 3'd1;
    localparam logic [2:0] TX_DATA   = 3'd2;
    localparam logic [2:0] TX_PARITY = 3'd3;
    localparam logic [2:0] TX_STOP   = 3'd4;

    localparam logic [2:0] RX_IDLE   = 3'd0;
    localparam logic [2:0] RX_START  = 3'd1;
    localparam logic [2:0] RX_DATA   = 3'd2;
    localparam logic [2:0] RX_PARITY = 3'd3;
    localparam logic [2:0] RX_STOP   = 3'd4;

    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_fifo
// Description : Synchronous first-word-fall-through FIFO; push on full is
//               accepted only when a pop frees a slot in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int          c_aw  = $clog2(DEPTH);
    localparam logic [c_aw:0] c_one = (c_aw + 1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw:0]    r_wr_ptr;
    logic [c_aw:0]    r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                       (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);
    assign rd_data   = r_mem[r_rd_ptr[c_aw-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_one;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_one;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_aw-1:0]] <= wr_data;
    end

endmodule
`default_nettype wire

// File: rtl/uart_core.sv
`default_nettype none
// ============================================================================
// Module      : uart_core
// Description : UART with runtime divisor/parity/stop config, 16x oversampled
//               majority-vote receiver, TX/RX FIFOs and error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_core
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int TX_DEPTH  = 16,
    parameter int RX_DEPTH  = 16,
    parameter int DIV_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic                 tx,
    input  logic [DIV_W-1:0]     baud_div,
    input  logic [1:0]           parity_mode,
    input  logic                 stop2,
    input  logic                 wr_en,
    input  logic [DATA_BITS-1:0] wr_data,
    output logic                 tx_full,
    output logic                 tx_idle,
    input  logic                 rd_en,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 rd_perr,
    output logic                 rd_ferr,
    output logic                 rx_empty,
    output logic                 rx_overrun,
    input  logic                 clr_overrun
);

    localparam logic [DIV_W-1:0] c_div_one  = DIV_W'(1);
    localparam logic [3:0]       c_last_bit = 4'(DATA_BITS - 1);

    // ---------------- tick generator ----------------
    logic [DIV_W-1:0] r_tick_cnt;
    logic             w_tick;

    assign w_tick = (r_tick_cnt <= c_div_one);

    always_ff @(posedge clk) begin
        if (rst)         r_tick_cnt <= c_div_one;
        else if (w_tick) r_tick_cnt <= (baud_div == '0) ? c_div_one : baud_div;
        else             r_tick_cnt <= r_tick_cnt - c_div_one;
    end

    // ---------------- transmitter ----------------
    logic [DATA_BITS-1:0] w_tx_head, r_tx_shift, w_tx_shift_nxt;
    logic [2:0]           r_tx_state, w_tx_state_nxt;
    logic [3:0]           r_tx_bits, w_tx_bits_nxt;
    logic [4:0]           r_tx_ticks, w_tx_ticks_nxt;
    logic [1:0]           r_tx_mode, w_tx_mode_nxt;
    logic                 r_tx_par, w_tx_par_nxt, r_tx_stop2, w_tx_stop2_nxt;
    logic                 r_tx, w_tx_bit_nxt, w_tx_pop, w_tx_empty, w_tx_bit_end;

    uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(wr_en), .wr_data(wr_data), .pop(w_tx_pop),
        .rd_data(w_tx_head), .full(tx_full), .empty(w_tx_empty)
    );

    assign w_tx_bit_end = w_tick && (r_tx_ticks[3:0] == LAST_TICK);

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_shift_nxt = r_tx_shift;
        w_tx_bits_nxt  = r_tx_bits;
        w_tx_ticks_nxt = r_tx_ticks;
        w_tx_par_nxt   = r_tx_par;
        w_tx_mode_nxt  = r_tx_mode;
        w_tx_stop2_nxt = r_tx_stop2;
        w_tx_pop       = 1'b0;
        w_tx_bit_nxt   = 1'b1;
        if (r_tx_state != TX_IDLE && w_tick) w_tx_ticks_nxt = r_tx_ticks + 5'd1;
        case (r_tx_state)
            TX_IDLE:  w_tx_pop = !w_tx_empty;
            TX_START: if (w_tx_bit_end) begin
                w_tx_ticks_nxt = '0;
                w_tx_bits_nxt  = '0;
                w_tx_state_nxt = TX_DATA;
            end
            TX_DATA: if (w_tx_bit_end) begin
                w_tx_ticks_nxt = '0;
                w_tx_shift_nxt = r_tx_shift >> 1;
                w_tx_bits_nxt  = r_tx_bits + 4'd1;
                if (r_tx_bits == c_last_bit)
                    w_tx_state_nxt = parity_enabled(r_tx_mode) ? TX_PARITY : TX_STOP;
            end
            TX_PARITY: if (w_tx_bit_end) begin
                w_tx_ticks_nxt = '0;
                w_tx_state_nxt = TX_STOP;
            end
            TX_STOP: if (w_tick && r_tx_ticks == (r_tx_stop2 ? 5'd31 : 5'd15)) begin
                w_tx_ticks_nxt = '0;
                w_tx_state_nxt = TX_IDLE;
                w_tx_pop       = !w_tx_empty;  // chain the next frame with no idle gap
            end
            default: w_tx_state_nxt = TX_IDLE;
        endcase
        if (w_tx_pop) begin
            w_tx_shift_nxt = w_tx_head;
            w_tx_par_nxt   = ^w_tx_head;
            w_tx_mode_nxt  = parity_mode;
            w_tx_stop2_nxt = stop2;
            w_tx_ticks_nxt = '0;
            w_tx_state_nxt = TX_START;
        end
        case (w_tx_state_nxt)
            TX_START:  w_tx_bit_nxt = 1'b0;
            TX_DATA:   w_tx_bit_nxt = w_tx_shift_nxt[0];
            TX_PARITY: w_tx_bit_nxt = (w_tx_mode_nxt == PAR_ODD) ? ~w_tx_par_nxt : w_tx_par_nxt;
            default:   w_tx_bit_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_shift <= '0;
            r_tx_bits  <= '0;
            r_tx_ticks <= '0;
            r_tx_par   <= 1'b0;
            r_tx_mode  <= PAR_NONE;
            r_tx_stop2 <= 1'b0;
            r_tx       <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_shift <= w_tx_shift_nxt;
            r_tx_bits  <= w_tx_bits_nxt;
            r_tx_ticks <= w_tx_ticks_nxt;
            r_tx_par   <= w_tx_par_nxt;
            r_tx_mode  <= w_tx_mode_nxt;
            r_tx_stop2 <= w_tx_stop2_nxt;
            r_tx       <= w_tx_bit_nxt;
        end
    end

    assign tx      = r_tx;
    assign tx_idle = w_tx_empty && (r_tx_state == TX_IDLE);

    // ---------------- receiver ----------------
    logic [DATA_BITS-1:0] r_rx_shift, w_rx_shift_nxt;
    logic [DATA_BITS+1:0] w_rx_entry, w_rx_head;
    logic [2:0]           r_rx_state, w_rx_state_nxt;
    logic [3:0]           r_rx_ticks, w_rx_ticks_nxt, w_rx_ticks_inc, r_rx_bits, w_rx_bits_nxt;
    logic [1:0]           r_rx_samp, w_rx_samp_nxt, r_rx_mode, w_rx_mode_nxt;
    logic                 r_rx_s1, r_rx_s2, r_rx_parbit, w_rx_parbit_nxt;
    logic                 w_rx_vote, w_rx_vote_now, w_rx_push, w_rx_perr, w_rx_full;
    logic                 r_overrun;

    assign w_rx_ticks_inc = r_rx_ticks + 4'd1;
    assign w_rx_vote      = majority3(r_rx_samp[1], r_rx_samp[0], r_rx_s2);
    assign w_rx_vote_now  = w_tick && (w_rx_ticks_inc == SAMPLE_TICK_C);
    assign w_rx_perr      = parity_enabled(r_rx_mode) &
                            ((^r_rx_shift) ^ r_rx_parbit ^ (r_rx_mode == PAR_ODD));
    assign w_rx_entry     = {~w_rx_vote, w_rx_perr, r_rx_shift};

    // Tick counter free-wraps every 16 ticks, so each bit's vote lands on tick 9.
    always_comb begin
        w_rx_state_nxt  = r_rx_state;
        w_rx_ticks_nxt  = r_rx_ticks;
        w_rx_bits_nxt   = r_rx_bits;
        w_rx_samp_nxt   = r_rx_samp;
        w_rx_mode_nxt   = r_rx_mode;
        w_rx_shift_nxt  = r_rx_shift;
        w_rx_parbit_nxt = r_rx_parbit;
        w_rx_push       = 1'b0;
        case (r_rx_state)
            RX_IDLE: if (w_tick && !r_rx_s2) begin
                w_rx_state_nxt = RX_START;
                w_rx_ticks_nxt = '0;
                w_rx_mode_nxt  = parity_mode;
            end
            RX_START, RX_DATA, RX_PARITY, RX_STOP: begin
                if (w_tick) begin
                    w_rx_ticks_nxt = w_rx_ticks_inc;
                    if (w_rx_ticks_inc == SAMPLE_TICK_A || w_rx_ticks_inc == SAMPLE_TICK_B)
                        w_rx_samp_nxt = {r_rx_samp[0], r_rx_s2};
                end
                if (w_rx_vote_now) begin
                    case (r_rx_state)
                        RX_START: begin
                            w_rx_state_nxt = w_rx_vote ? RX_IDLE : RX_DATA;
                            w_rx_bits_nxt  = '0;
                        end
                        RX_DATA: begin
                            w_rx_shift_nxt = {w_rx_vote, r_rx_shift[DATA_BITS-1:1]};
                            w_rx_bits_nxt  = r_rx_bits + 4'd1;
                            if (r_rx_bits == c_last_bit)
                                w_rx_state_nxt = parity_enabled(r_rx_mode) ? RX_PARITY : RX_STOP;
                        end
                        RX_PARITY: begin
                            w_rx_parbit_nxt = w_rx_vote;
                            w_rx_state_nxt  = RX_STOP;
                        end
                        default: begin
                            w_rx_push      = 1'b1;
                            w_rx_state_nxt = RX_IDLE;
                        end
                    endcase
                end
            end
            default: w_rx_state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_s1     <= 1'b1;
            r_rx_s2     <= 1'b1;
            r_rx_state  <= RX_IDLE;
            r_rx_ticks  <= '0;
            r_rx_bits   <= '0;
            r_rx_samp   <= '0;
            r_rx_mode   <= PAR_NONE;
            r_rx_shift  <= '0;
            r_rx_parbit <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_rx_s1     <= rx;
            r_rx_s2     <= r_rx_s1;
            r_rx_state  <= w_rx_state_nxt;
            r_rx_ticks  <= w_rx_ticks_nxt;
            r_rx_bits   <= w_rx_bits_nxt;
            r_rx_samp   <= w_rx_samp_nxt;
            r_rx_mode   <= w_rx_mode_nxt;
            r_rx_shift  <= w_rx_shift_nxt;
            r_rx_parbit <= w_rx_parbit_nxt;
            if (w_rx_push && w_rx_full && !rd_en) r_overrun <= 1'b1;
            else if (clr_overrun)                 r_overrun <= 1'b0;
        end
    end

    uart_fifo #(.WIDTH(DATA_BITS + 2), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(w_rx_push), .wr_data(w_rx_entry), .pop(rd_en),
        .rd_data(w_rx_head), .full(w_rx_full), .empty(rx_empty)
    );

    assign rd_data    = rx_empty ? '0 : w_rx_head[DATA_BITS-1:0];
    assign rd_perr    = ~rx_empty & w_rx_head[DATA_BITS];
    assign rd_ferr    = ~rx_empty & w_rx_head[DATA_BITS+1];
    assign rx_overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_core
// Description : Scoreboarded bench for uart_core: TX waveform, loopback,
//               RX error flags, false start, overrun and mid-frame reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_core;

    localparam int DB  = 8;
    localparam int TXD = 4;
    localparam int RXD = 4;
    localparam int DW  = 16;

    logic          clk = 1'b0;
    logic          rst, rx, tx, stop2, wr_en, tx_full, tx_idle, rd_en;
    logic          rd_perr, rd_ferr, rx_empty, rx_overrun, clr_overrun;
    logic [DW-1:0] baud_div;
    logic [1:0]    parity_mode;
    logic [DB-1:0] wr_data, rd_data;
    logic          loop_en, rx_drv;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [DB+1:0] exp_q[$];
    bit            mon_en = 1'b0;

    assign rx = loop_en ? tx : rx_drv;
    always #5 clk = ~clk;

    uart_core #(.DATA_BITS(DB), .TX_DEPTH(TXD), .RX_DEPTH(RXD), .DIV_W(DW)) dut (
        .clk(clk), .rst(rst), .rx(rx), .tx(tx), .baud_div(baud_div),
        .parity_mode(parity_mode), .stop2(stop2), .wr_en(wr_en), .wr_data(wr_data),
        .tx_full(tx_full), .tx_idle(tx_idle), .rd_en(rd_en), .rd_data(rd_data),
        .rd_perr(rd_perr), .rd_ferr(rd_ferr), .rx_empty(rx_empty),
        .rx_overrun(rx_overrun), .clr_overrun(clr_overrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Monitor: pops every RX entry the DUT presents and checks it against the queue.
    initial begin
        rd_en = 1'b0;
        forever begin
            @(negedge clk);
            rd_en = 1'b0;
            if (mon_en && !rst && !rx_empty) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rx_unexpected: got 0x%0h, expected no entry",
                             {rd_ferr, rd_perr, rd_data});
                end else begin
                    check("rx_entry", {rd_ferr, rd_perr, rd_data}, exp_q.pop_front());
                end
                rd_en = 1'b1;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic v, input int n);
        rx_drv = v;
        repeat (n) @(negedge clk);
    endtask

    // Serialises one frame onto rx and records the expected FIFO entry.
    task automatic rx_frame(input logic [DB-1:0] d, input logic [1:0] pm, input bit pflip,
                            input bit stop_v, input bit brk, input int gbit, input bit keep);
        int   dv;
        int   bc;
        logic en, pc, ps, v;
        dv = int'(baud_div);
        bc = 16 * dv;
        en = (pm == 2'd1) || (pm == 2'd2);
        pc = (pm == 2'd2) ? ~(^d) : ^d;
        ps = brk ? 1'b0 : (pc ^ pflip);
        if (keep)
            exp_q.push_back({brk ? 1'b1 : ~stop_v, en && (ps != pc), brk ? {DB{1'b0}} : d});
        parity_mode = pm;
        drive(1'b0, bc);
        for (int i = 0; i < DB; i++) begin
            v = brk ? 1'b0 : d[i];
            if (i == gbit) begin
                drive(v, 8 * dv);
                drive(~v, dv);
                drive(v, bc - 9 * dv);
            end else begin
                drive(v, bc);
            end
        end
        if (en) drive(ps, bc);
        drive((brk ? 1'b0 : stop_v), bc);
        drive(1'b1, (stop_v && !brk) ? bc : 2 * bc);
    endtask

    task automatic push_tx(input logic [DB-1:0] d);
        int b = 0;
        while (tx_full && b < 20000) begin
            @(negedge clk);
            b++;
        end
        if (b >= 20000) check("tx_full_wait", 32'(tx_full), 32'd0);
        wr_data = d;
        wr_en   = 1'b1;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int b = 0;
        while (exp_q.size() != 0 && b < budget) begin
            @(negedge clk);
            b++;
        end
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic wait_tx_idle(input int budget);
        int b = 0;
        while (!tx_idle && b < budget) begin
            @(negedge clk);
            b++;
        end
        check("tx_idle_wait", 32'(tx_idle), 32'd1);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int            t_edge[12];
        logic          lvl[12];
        logic          prev;
        logic [9:0]    lv;
        int            ne, t_idle, lows;
        logic [DB-1:0] d;

        rst = 1'b1; rx_drv = 1'b1; loop_en = 1'b0; baud_div = 16'd2;
        parity_mode = 2'd0; stop2 = 1'b0; wr_en = 1'b0; wr_data = '0; clr_overrun = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_tx_full", 32'(tx_full), 32'd0);
        check("rst_tx_idle", 32'(tx_idle), 32'd1);
        check("rst_rx_empty", 32'(rx_empty), 32'd1);
        check("rst_rx_overrun", 32'(rx_overrun), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_rd_flags", 32'({rd_ferr, rd_perr}), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 8N1 0x55 at baud_div=2: every boundary toggles, bits 32 clocks
        wr_data = 8'h55; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        check("tx_before_start", 32'(tx), 32'd1);
        @(negedge clk);
        check("tx_start_n2", 32'(tx), 32'd0);
        ne = 1; t_edge[0] = 0; lvl[0] = tx; prev = tx; t_idle = -1;
        for (int t = 1; t < 800 && t_idle < 0; t++) begin
            @(negedge clk);
            if (tx !== prev && ne < 12) begin
                t_edge[ne] = t; lvl[ne] = tx; ne++; prev = tx;
            end
            if (tx_idle && ne >= 10) t_idle = t;
        end
        check("tx_edges", ne, 10);
        for (int i = 0; i < 10; i++) lv[i] = lvl[i];
        check("tx_levels", 32'(lv), 32'({1'b1, 8'h55, 1'b0}));
        check_rng("tx_start_len", t_edge[1] - t_edge[0], 31, 32);
        for (int i = 1; i < 9; i++) check("tx_bit_len", t_edge[i+1] - t_edge[i], 32);
        check("tx_stop_len", t_idle - t_edge[9], 32);

        // Loopback 8E2
        loop_en = 1'b1; parity_mode = 2'd1; stop2 = 1'b1; mon_en = 1'b1;
        repeat (40) @(negedge clk);
        exp_q.push_back({2'b00, 8'hA5}); push_tx(8'hA5);
        exp_q.push_back({2'b00, 8'h00}); push_tx(8'h00);
        exp_q.push_back({2'b00, 8'hFF}); push_tx(8'hFF);
        wait_drain("loop_8e2_drain", 8000);
        wait_tx_idle(2000);

        // Randomised loopback batches with random divisor, parity and stop bits
        for (int b = 0; b < 3; b++) begin
            baud_div    = 16'($urandom_range(1, 3));
            parity_mode = 2'($urandom_range(0, 3));
            stop2       = 1'($urandom_range(0, 1));
            for (int i = 0; i < 4; i++) begin
                d = 8'($urandom);
                exp_q.push_back({2'b00, d});
                push_tx(d);
            end
            wait_drain("loop_rand_drain", 12000);
            wait_tx_idle(3000);
        end

        // Six back-to-back writes: the FSM takes one, the FIFO keeps TXD, the last is dropped
        baud_div = 16'd1; parity_mode = 2'd0; stop2 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            d = 8'(8'h30 + i);
            if (i < TXD + 1) exp_q.push_back({2'b00, d});
            wr_data = d; wr_en = 1'b1;
            @(negedge clk);
        end
        wr_en = 1'b0;
        check("tx_full_after_burst", 32'(tx_full), 32'd1);
        wait_drain("tx_full_drain", 6000);
        wait_tx_idle(2000);

        // RX driven by the bench, 8O1 with errors
        loop_en = 1'b0; rx_drv = 1'b1; baud_div = 16'd2;
        repeat (40) @(negedge clk);
        rx_frame(8'h3C, 2'd2, 1'b1, 1'b1, 1'b0, -1, 1'b1);
        rx_frame(8'h81, 2'd2, 1'b0, 1'b0, 1'b0, -1, 1'b1);
        wait_drain("rx_err_drain", 2000);

        for (int i = 0; i < 10; i++) begin
            rx_frame(8'($urandom), 2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
                     ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, DB - 1)) : -1, 1'b1);
        end
        wait_drain("rx_rand_drain", 2000);

        // 6-tick low pulse is a false start
        drive(1'b0, 6 * 2);
        drive(1'b1, 3 * 32);
        check("false_start_empty", 32'(rx_empty), 32'd1);

        // Overrun: RXD entries kept, the extra one dropped
        mon_en = 1'b0; parity_mode = 2'd0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < RXD; i++) rx_frame(8'($urandom), 2'd0, 1'b0, 1'b1, 1'b0, -1, 1'b1);
        check("overrun_before", 32'(rx_overrun), 32'd0);
        rx_frame(8'hE7, 2'd0, 1'b0, 1'b1, 1'b0, -1, 1'b0);
        check("overrun_set", 32'(rx_overrun), 32'd1);
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        check("overrun_cleared", 32'(rx_overrun), 32'd0);
        mon_en = 1'b1;
        wait_drain("overrun_drain", 200);
        repeat (4) @(negedge clk);
        check("overrun_fifo_empty", 32'(rx_empty), 32'd1);

        // Reset in the middle of a TX data bit with three characters queued
        for (int i = 0; i < 4; i++) begin
            wr_data = 8'(8'hC0 + i); wr_en = 1'b1;
            @(negedge clk);
        end
        wr_en = 1'b0;
        begin
            int b = 0;
            while (tx && b < 200) begin
                @(negedge clk);
                b++;
            end
            check("rst_test_start", 32'(tx), 32'd0);
        end
        repeat (2 * 32 + 10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_tx", 32'(tx), 32'd1);
        check("midrst_tx_idle", 32'(tx_idle), 32'd1);
        check("midrst_tx_full", 32'(tx_full), 32'd0);
        lows = 0;
        repeat (600) begin
            @(negedge clk);
            if (!tx) lows++;
        end
        check("midrst_quiet", lows, 0);
        check("midrst_still_idle", 32'(tx_idle), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
